// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply (single cycle) and 32-step restoring divide unit.
// Build option DIV_ZERO_FAST_EN: a divide by zero skips the BUSY iterations.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        annul_i,
    input  logic        ex_hold_i,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int         DIV_STEPS = 32;
    localparam logic [7:0] OP_MULT   = 8'b00011000;
    localparam logic [7:0] OP_MULTU  = 8'b00011001;
    localparam logic [7:0] OP_DIV    = 8'b00011010;
    localparam logic [7:0] OP_DIVU   = 8'b00011011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo, r_rem, r_dvs, r_a;
    logic        r_qneg, r_rneg, r_dz;

    logic        w_is_mul, w_is_div, w_sgn, w_start, w_dz, w_fast;
    logic [31:0] w_a1, w_a2;
    logic signed [63:0] w_ps;
    logic [63:0] w_pu;
    logic [32:0] w_sh, w_diff;
    logic        w_stall, w_we;
    logic [31:0] w_hi, w_lo;

    assign w_is_mul = aluop_i == OP_MULT || aluop_i == OP_MULTU;
    assign w_is_div = aluop_i == OP_DIV || aluop_i == OP_DIVU;
    assign w_sgn    = aluop_i == OP_DIV;
    assign w_start  = r_state == IDLE && w_is_div && !annul_i;
    assign w_dz     = reg2_i == 32'd0;
    assign w_a1     = w_sgn && reg1_i[31] ? -reg1_i : reg1_i;
    assign w_a2     = w_sgn && reg2_i[31] ? -reg2_i : reg2_i;
    assign w_ps     = $signed(reg1_i) * $signed(reg2_i);
    assign w_pu     = {32'd0, reg1_i} * {32'd0, reg2_i};
    // Remainder shifts in the next dividend bit; a clear borrow means the divisor fits.
    assign w_sh     = {r_rem, r_quo[31]};
    assign w_diff   = w_sh - {1'b0, r_dvs};
`ifdef DIV_ZERO_FAST_EN
    assign w_fast   = w_dz;
`else
    assign w_fast   = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_we    = 1'b0;
        w_hi    = 32'd0;
        w_lo    = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_stall = 1'b1;
                    w_next  = w_fast ? DONE : BUSY;
                end else if (w_is_mul) begin
                    w_we = 1'b1;
                    {w_hi, w_lo} = aluop_i == OP_MULT ? w_ps : w_pu;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                w_next  = annul_i ? IDLE : r_cnt == 5'(DIV_STEPS - 1) ? DONE : BUSY;
            end
            DONE: begin
                w_next = annul_i || !ex_hold_i ? IDLE : DONE;
                w_we   = !annul_i;
                w_hi   = annul_i ? 32'd0 : r_dz ? r_a : r_rneg ? -r_rem : r_rem;
                w_lo   = annul_i ? 32'd0 : r_dz ? 32'hFFFFFFFF : r_qneg ? -r_quo : r_quo;
            end
            default: w_next = IDLE;
        endcase
    end

    assign stallreq_o = !rst && w_stall;
    assign hilo_we_o  = !rst && w_we;
    assign hi_o       = rst ? 32'd0 : w_hi;
    assign lo_o       = rst ? 32'd0 : w_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_dvs   <= 32'd0;
            r_a     <= 32'd0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt  <= 5'd0;
                r_quo  <= w_a1;
                r_rem  <= 32'd0;
                r_dvs  <= w_a2;
                r_a    <= reg1_i;
                r_qneg <= w_sgn && (reg1_i[31] ^ reg2_i[31]);
                r_rneg <= w_sgn && reg1_i[31];
                r_dz   <= w_dz;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 5'd1;
                r_rem <= w_diff[32] ? w_sh[31:0] : w_diff[31:0];
                r_quo <= {r_quo[30:0], !w_diff[32]};
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv (multiply, divide, hold, annul, reset).
module tb_ex_muldiv;
    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
    localparam logic [7:0] OP_DIVU  = 8'b00011011;
`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = 8'd0;
    logic [31:0] reg1_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic        annul_i = 1'b0;
    logic        ex_hold_i = 1'b0;
    logic        stallreq_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] sb[$];

    ex_muldiv dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .annul_i(annul_i), .ex_hold_i(ex_hold_i), .stallreq_o(stallreq_o),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Held results are compared every cycle but retired only when the write actually lands.
    always @(negedge clk) begin
        if (!rst && hilo_we_o) begin
            if (sb.size() == 0) chk("spurious_we", 64'(hilo_we_o), 64'd0);
            else begin
                chk("hilo", {hi_o, lo_o}, sb[0]);
                if (!ex_hold_i) void'(sb.pop_front());
            end
        end else if (!rst) chk("hilo_zero", {hi_o, lo_o}, 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
        aluop_i = op; reg1_i = a; reg2_i = b;
        sb.push_back(exp);
        @(negedge clk);
        chk("mul_stall", 64'(stallreq_o), 64'd0);
        chk("mul_we", 64'(hilo_we_o), 64'd1);
        step();
        aluop_i = 8'd0;
    endtask

    task automatic div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat_exp, input int hold_n);
        int lat = 0;
        int ns = 0;
        aluop_i = op; reg1_i = a; reg2_i = b; ex_hold_i = hold_n > 0;
        sb.push_back(exp);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hilo_we_o) break;
            ns += int'(stallreq_o);
            lat++;
        end
        chk("div_lat", 64'(lat), 64'(lat_exp));
        chk("div_stall_cycles", 64'(ns), 64'(lat_exp));
        chk("done_stall", 64'(stallreq_o), 64'd0);
        for (int j = 0; j < hold_n; j++) begin
            step();
            if (j == hold_n - 1) ex_hold_i = 1'b0;
            @(negedge clk);
            chk("hold_we", 64'(hilo_we_o), 64'd1);
        end
        step();
        aluop_i = 8'd0;
        ex_hold_i = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        int ns = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ns += int'(stallreq_o);
        end
        chk(tag, 64'(ns), 64'd0);
        step();
    endtask

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("rst_outputs", {31'd0, stallreq_o, hilo_we_o, hi_o, lo_o}, 65'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {31'd0, stallreq_o, hilo_we_o, hi_o, lo_o}, 65'd0);
        step();

        mul(OP_MULT,  32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
        mul(OP_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA);
        mul(OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000);

        aluop_i = 8'h20; reg1_i = 32'h12345678; reg2_i = 32'h9;
        @(negedge clk);
        chk("other_op", {31'd0, stallreq_o, hilo_we_o, hi_o, lo_o}, 65'd0);
        step();

        div(OP_DIV,  32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
        div(OP_DIV,  32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
        div(OP_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 3);
        div(OP_DIVU, 32'hFFFFFFFF, 32'd16, 64'h0000000F_0FFFFFFF, 33, 0);

        aluop_i = OP_DIV; reg1_i = 32'd20; reg2_i = 32'd3;
        repeat (10) step();
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_stall_now", 64'(stallreq_o), 64'd1);
        step();
        annul_i = 1'b0; aluop_i = 8'd0;
        quiet("annul_stall_after", 40);

        div(OP_DIVU, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

        aluop_i = OP_DIV; reg1_i = 32'd20; reg2_i = 32'd3; annul_i = 1'b1;
        @(negedge clk);
        chk("annul_idle_stall", 64'(stallreq_o), 64'd0);
        step();
        annul_i = 1'b0; aluop_i = 8'd0;
        quiet("annul_idle_quiet", 40);

        div(OP_DIVU, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, DZ_LAT, 0);
        div(OP_DIV,  32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, DZ_LAT, 0);

        aluop_i = OP_DIV; reg1_i = 32'd20; reg2_i = 32'd3;
        repeat (5) step();
        rst = 1'b1; aluop_i = 8'd0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_outputs", {31'd0, stallreq_o, hilo_we_o, hi_o, lo_o}, 65'd0);
        quiet("mid_rst_quiet", 40);

        div(OP_DIV, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
